// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 calculator keypad.
//   - kp_state_t  : debounce FSM state encoding
//   - scan_kind_t : per-scan reduction result (none / single / multi)
//   - KEY_0..KEY_F: keycode constants
//   - LINE_0..3   : one-hot column/row line constants
//   - key_lookup  : (column, row) -> keycode, shared with the keypad decoder
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } kp_state_t;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_kind_t;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  localparam logic [3:0] LINE_0 = 4'b0001;
  localparam logic [3:0] LINE_1 = 4'b0010;
  localparam logic [3:0] LINE_2 = 4'b0100;
  localparam logic [3:0] LINE_3 = 4'b1000;

  function automatic logic [3:0] key_lookup(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] code;
    case ({col, row})
      4'h0: code = KEY_1;
      4'h1: code = KEY_4;
      4'h2: code = KEY_7;
      4'h3: code = KEY_E;
      4'h4: code = KEY_2;
      4'h5: code = KEY_5;
      4'h6: code = KEY_8;
      4'h7: code = KEY_0;
      4'h8: code = KEY_3;
      4'h9: code = KEY_6;
      4'hA: code = KEY_9;
      4'hB: code = KEY_F;
      4'hC: code = KEY_A;
      4'hD: code = KEY_B;
      4'hE: code = KEY_C;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// keypad_scanner: synchronizes the row lines, rotates the one-hot column
// drive, samples the rows on the last dwell cycle of each column and reduces
// one full scan to NONE / SINGLE(code) / MULTI.
//   clk, reset       : clock, synchronous active-high reset
//   rows[3:0]        : raw row lines (asynchronous)
//   columns[3:0]     : one-hot column drive
//   scan_done        : high on the column-3 sample cycle (scan result valid)
//   scan_kind        : NONE / SINGLE / MULTI for the completed scan
//   scan_code[3:0]   : keycode when scan_kind is SINGLE
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic       scan_done,
  output scan_kind_t scan_kind,
  output logic [3:0] scan_code
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [3:0]    rows_s1, rows_s2;
  logic [DW-1:0] dwell;
  logic [1:0]    col;
  logic [1:0]    acc_hits, samp_hits, total_hits;
  logic [3:0]    acc_code, samp_code, total_code;
  logic [2:0]    hit_sum;
  logic          sample_tc;

  // Dwell down-counter: 0 marks the first cycle of a column and reloads;
  // terminal count 1 is the last cycle, where the rows are sampled.
  assign sample_tc = (dwell == DW'(1));
  assign scan_done = sample_tc && (col == 2'd3);

  always_comb begin
    case (col)
      2'd0:    columns = LINE_0;
      2'd1:    columns = LINE_1;
      2'd2:    columns = LINE_2;
      default: columns = LINE_3;
    endcase
  end

  // Hit counts saturate at 2: anything above one is simply "multi".
  always_comb begin
    samp_hits = 2'd0;
    samp_code = 4'd0;
    for (int r = 0; r < 4; r++) begin
      if (rows_s2[r]) begin
        if (samp_hits != 2'd2) samp_hits = samp_hits + 2'd1;
        samp_code = key_lookup(col, 2'(r));
      end
    end
    hit_sum    = {1'b0, acc_hits} + {1'b0, samp_hits};
    total_hits = (hit_sum > 3'd1) ? 2'd2 : hit_sum[1:0];
    total_code = (acc_hits != 2'd0) ? acc_code : samp_code;
    case (total_hits)
      2'd0:    scan_kind = SCAN_NONE;
      2'd1:    scan_kind = SCAN_SINGLE;
      default: scan_kind = SCAN_MULTI;
    endcase
    scan_code = total_code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_s1  <= 4'd0;
      rows_s2  <= 4'd0;
      dwell    <= '0;
      col      <= 2'd0;
      acc_hits <= 2'd0;
      acc_code <= 4'd0;
    end else begin
      rows_s1 <= rows;
      rows_s2 <= rows_s1;
      dwell   <= (dwell == '0) ? DW'(SCAN_DIV - 1) : dwell - DW'(1);
      if (sample_tc) begin
        col <= col + 2'd1;
        if (col == 2'd3) begin
          acc_hits <= 2'd0;
          acc_code <= 4'd0;
        end else begin
          acc_hits <= total_hits;
          acc_code <= total_code;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scan_controller.sv
// keypad_scan_controller: scans the 4x4 keypad, debounces whole scans and
// hands one keycode per press to the consumer over valid/ready.
//   clk, reset    : clock, synchronous active-high reset
//   rows[3:0]     : raw row lines (asynchronous)
//   columns[3:0]  : one-hot column drive
//   key_valid     : keycode available, held until accepted
//   key_ready     : consumer accepts when key_valid & key_ready
//   key_code[3:0] : accepted keycode, stable while key_valid
//   key_held      : accepted key still considered pressed
//   overflow      : one-cycle pulse when a press is dropped
//
// state     | meaning
// IDLE      | no key; waiting for a SINGLE scan
// PRESS_CHK | counting consecutive SINGLE scans of the candidate key
// HELD      | key accepted and still down; no auto-repeat
// REL_CHK   | counting consecutive non-SINGLE scans before release
module keypad_scan_controller
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic       overflow
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DS_C = CW'(DEBOUNCE_SCANS);

  logic          scan_done;
  scan_kind_t    scan_kind;
  logic [3:0]    scan_code;
  kp_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0]    cand, cand_nxt;
  logic          accept, single, hs;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .columns   (columns),
    .scan_done (scan_done),
    .scan_kind (scan_kind),
    .scan_code (scan_code)
  );

  assign single   = (scan_kind == SCAN_SINGLE);
  assign cnt_inc  = cnt + CW'(1);
  assign key_held = (state == HELD) || (state == REL_CHK);
  assign hs       = key_valid && key_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    accept    = 1'b0;
    if (scan_done) begin
      case (state)
        IDLE: begin
          if (single) begin
            cand_nxt = scan_code;
            if (DEBOUNCE_SCANS == 1) begin
              accept    = 1'b1;
              state_nxt = HELD;
            end else begin
              cnt_nxt   = CW'(1);
              state_nxt = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (!single) begin
            state_nxt = IDLE;
          end else if (scan_code != cand) begin
            cand_nxt = scan_code;
            cnt_nxt  = CW'(1);
          end else if (cnt_inc == DS_C) begin
            accept    = 1'b1;
            state_nxt = HELD;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        HELD: begin
          if (!single) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_nxt = IDLE;
            end else begin
              cnt_nxt   = CW'(1);
              state_nxt = REL_CHK;
            end
          end
        end
        default: begin
          if (single)                 state_nxt = HELD;
          else if (cnt_inc == DS_C)   state_nxt = IDLE;
          else                        cnt_nxt   = cnt_inc;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
    end
  end

  // A handshake completing in the accept cycle frees the output slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (accept && key_valid && !hs) begin
        overflow <= 1'b1;
      end else if (accept) begin
        key_valid <= 1'b1;
        key_code  <= scan_code;
      end else if (hs) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_controller.sv
// tb_keypad_scan_controller: physical keypad matrix model driving the rows,
// a per-scan behavioural key model, and a scoreboard of expected keycodes
// popped by an independent handshake monitor.
module tb_keypad_scan_controller;

  localparam int SD = 4;
  localparam int DS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows;
  logic [3:0] columns;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic [3:0] key_code;
  logic       key_held;
  logic       overflow;

  always #5 clk = ~clk;

  keypad_scan_controller #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .columns   (columns),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_code  (key_code),
    .key_held  (key_held),
    .overflow  (overflow)
  );

  // Pressed keys as a 16-bit mask, index = column*4 + row.
  logic [15:0] pressed = 16'd0;

  always_comb begin
    rows = 4'd0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && columns[c]) rows[r] = 1'b1;
  end

  logic [3:0] code_map [16] = '{4'h1, 4'h4, 4'h7, 4'hE,
                                4'h2, 4'h5, 4'h8, 4'h0,
                                4'h3, 4'h6, 4'h9, 4'hF,
                                4'hA, 4'hB, 4'hC, 4'hD};

  int         n_checks = 0;
  int         n_pass = 0;
  logic [3:0] exp_q[$];
  int         ovf_exp = 0;
  int         ovf_seen = 0;

  bit m_held = 0, m_pending = 0, m_ovf_now = 0, rmode = 1;
  int m_streak = 0, m_rel = 0;
  logic [3:0] m_code = 4'd0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every completed handshake must match the oldest expected code.
  always @(negedge clk) begin
    if (!reset) begin
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) chk("unexpected_key", 1, 0);
        else chk("key_code", int'(key_code), int'(exp_q.pop_front()));
      end
      if (overflow) ovf_seen++;
    end
  end

  // One scan's worth of keypad behaviour, from the pressed set alone.
  task automatic model_scan(input logic [15:0] mask);
    int n;
    logic [3:0] code;
    bit acc;
    n = $countones(mask);
    code = 4'd0;
    acc = 0;
    m_ovf_now = 0;
    for (int i = 0; i < 16; i++) if (mask[i]) code = code_map[i];
    if (!m_held) begin
      if (n == 1) begin
        if (m_streak > 0 && code == m_code) m_streak++;
        else begin m_code = code; m_streak = 1; end
        if (m_streak == DS) begin acc = 1; m_held = 1; m_rel = 0; m_streak = 0; end
      end else m_streak = 0;
    end else begin
      if (n == 1) m_rel = 0;
      else begin
        m_rel++;
        if (m_rel == DS) begin m_held = 0; m_rel = 0; end
      end
    end
    if (acc) begin
      if (m_pending) begin m_ovf_now = 1; ovf_exp++; end
      else begin exp_q.push_back(code); m_pending = 1; end
    end
  endtask

  // Starts and ends on the negedge of the first cycle of a scan.
  task automatic run_scan(input logic [15:0] mask, input bit drain);
    pressed = mask;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      chk("columns", int'(columns), 1 << (i / 4));
      if (i == 2 && drain) chk("drain_clears_valid", int'(key_valid), 0);
      @(posedge clk);
      if (i == 0) begin #1; key_ready = drain | rmode; end
      if (i == 1) begin #1; if (key_ready) m_pending = 0; key_ready = rmode; end
    end
    model_scan(mask);
    @(negedge clk);
    chk("key_valid", int'(key_valid), int'(m_pending));
    chk("key_held", int'(key_held), int'(m_held));
    chk("overflow", int'(overflow), int'(m_ovf_now));
    if (key_ready) m_pending = 0;
  endtask

  task automatic scans(input logic [15:0] mask, input int n);
    for (int k = 0; k < n; k++) run_scan(mask, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_held = 0; m_pending = 0; m_streak = 0; m_rel = 0;
  endtask

  function automatic logic [15:0] k(input int idx);
    return 16'd1 << idx;
  endfunction

  initial begin
    logic [15:0] mask;
    int sel, len;
    do_reset();
    chk("reset_key_valid", int'(key_valid), 0);
    chk("reset_key_code", int'(key_code), 0);
    chk("reset_key_held", int'(key_held), 0);
    chk("reset_overflow", int'(overflow), 0);

    rmode = 1;
    scans(16'd0, 5);
    scans(k(5), 4);                          // "5" with ready high
    scans(16'd0, 4);

    rmode = 0;
    scans(k(15), 4);                         // "D" with ready low
    scans(16'd0, 4);
    run_scan(16'd0, 1);

    rmode = 1;
    run_scan(k(2), 0);                       // "7" bouncing
    run_scan(16'd0, 0);
    scans(k(2), 3);
    scans(16'd0, 4);

    scans(k(0) | k(4), 3);                   // "1"+"2" together
    scans(k(0), 3);
    scans(16'd0, 4);

    rmode = 0;
    scans(k(8), 3);                          // "3", then "9" dropped
    scans(16'd0, 3);
    scans(k(10), 3);
    scans(16'd0, 3);
    run_scan(16'd0, 1);

    rmode = 1;
    scans(k(5), 2);                          // reset mid-debounce
    do_reset();
    scans(k(5), 2);
    scans(k(5), 2);
    scans(16'd0, 4);

    for (int seg = 0; seg < 60; seg++) begin
      sel = $urandom_range(0, 99);
      if (sel < 40) mask = 16'd0;
      else if (sel < 85) mask = k($urandom_range(0, 15));
      else mask = k($urandom_range(0, 15)) | k($urandom_range(0, 15));
      rmode = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 5);
      scans(mask, len);
    end

    rmode = 1;
    scans(16'd0, 5);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("overflow_count", ovf_seen, ovf_exp);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan_controller.md
# keypad_scan_controller

Drives the column lines of the 4x4 calculator keypad, samples the row lines, and debounces the result. Emits one registered keycode per physical key press through a valid/ready handshake toward the calculator input logic. The key-to-code mapping is the same one the keypad decoder uses, so downstream logic sees identical codes.

## Interface

Parameters:
- SCAN_DIV, default 1000: clk cycles each column is driven. Must be ≥ 4.
- DEBOUNCE_SCANS, default 4: number of consecutive identical full scans needed to accept a press or a release. Must be ≥ 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rows  in  4  raw keypad row inputs, active-high, asynchronous to clk
- columns  out  4  one-hot active-high column drive
- key_valid  out  1  keycode available; held until accepted
- key_ready  in  1  consumer accepts key_code when key_valid & key_ready
- key_code  out  4  accepted keycode; stable while key_valid
- key_held  out  1  high while the accepted key is still considered pressed
- overflow  out  1  one-cycle pulse when a press is dropped

## Operation

- rows pass through a 2-flop synchronizer before any use.
- **Scanner**
  - Column index c cycles 0→1→2→3→0. columns = 1<<c.
  - Dwell is SCAN_DIV cycles per column.
  - Synchronized rows are sampled on the last dwell cycle of each column.
- **Keycode map** (column c, row r = bit index):
  - c0: 1, 4, 7, E
  - c1: 2, 5, 8, 0
  - c2: 3, 6, 9, F
  - c3: A, B, C, D
- **Scan result**, evaluated at the end of column 3:
  - SINGLE(code): exactly one row bit set across all four samples.
  - NONE: no row bit set.
  - MULTI: more than one row bit set. MULTI is treated as NONE for release counting, but it never confirms a press.
- **Debounce FSM** (counter cnt):
  - IDLE: on SINGLE, set cand=code, cnt=1, go to PRESS_CHK. If DEBOUNCE_SCANS=1, accept immediately instead.
  - PRESS_CHK:
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_SCANS, accept and go to HELD.
    - SINGLE(other): restart with the new cand, cnt=1.
    - NONE or MULTI: go to IDLE.
  - HELD:
    - key_held=1.
    - NONE or MULTI: cnt=1, go to REL_CHK.
    - SINGLE(any): stay in HELD. There is no auto-repeat.
  - REL_CHK:
    - NONE or MULTI: cnt+1. When cnt reaches DEBOUNCE_SCANS, go to IDLE and set key_held=0.
    - SINGLE: return to HELD.
- **Accept**
  - If key_valid=0: load key_code=cand and set key_valid=1.
  - If key_valid=1 (previous key not consumed): keep the old key_code, pulse overflow, still enter HELD.
- **Handshake**: key_valid clears on the cycle after key_valid & key_ready. An accept in the same cycle as the handshake completes counts as key_valid=0.

## Timing

- **Reset values**: columns=4'b0001, key_valid=0, key_code=0, key_held=0, overflow=0. FSM=IDLE, c=0, dwell and debounce counters 0, synchronizer flops 0.
- **Scan period**: 4·SCAN_DIV cycles. Column changes on the cycle after the sample cycle.
- **Press latency**: key_valid rises one cycle after the end-of-scan evaluation of the DEBOUNCE_SCANS-th consecutive SINGLE scan. Rows must be stable ≥ 3 cycles before each sample; 2 of those cycles are synchronizer delay.
- key_held rises with key_valid, or with overflow on a dropped press. It falls one cycle after the deciding release evaluation.
- Reset mid-scan or mid-debounce discards everything; no event is emitted.
- key_ready is ignored while key_valid=0.

## Structure

- **Shared package keypad_pkg**:
  - FSM state encoding (IDLE, PRESS_CHK, HELD, REL_CHK).
  - Keycode constants (KEY_0..KEY_9, KEY_A..KEY_F).
  - 4-bit one-hot column/row constants, also used by the decoder.
- **Sub-module keypad_scanner**: synchronizer, dwell counter, column rotation, per-scan SINGLE/NONE/MULTI reduction and code lookup. Outputs scan_done, scan_kind, scan_code.
- **Top level**: debounce FSM and handshake.

## Test plan

All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=3 (scan period 16 cycles).

- Reset, then no key for 5 scans → columns rotates 0001→0010→0100→1000 every 4 cycles; key_valid=0, key_held=0 throughout.
- Key "5" held (rows=0010 whenever columns=0010) with key_ready=1 → key_valid pulses once, key_code=5, one cycle after the 3rd scan end. Release for 3 scans → key_held falls.
- Key "D" (c3, r3) held with key_ready=0 → key_valid stays high with key_code=D. Raise key_ready → key_valid clears next cycle.
- Key "7" bounces (present, absent, present, present, present per scan) → no accept until 3 consecutive SINGLE scans, i.e. key_valid after scan 5.
- "1" and "2" pressed together → MULTI, no key_valid. Release "2" → "1" accepted after 3 scans.
- key_ready=0: press "3", release, press "9" → key_code stays 3, overflow pulses once at the "9" accept, key_held=1.
